key_press_detector: RTL and testbench
=====================================

Name: key_press_detector

Overview:
Conditions one raw mechanical push-button and turns it into clean, single-cycle events: press, release, short press, and a 3 s long press.
It sits directly upstream of the ballplayer top-level mode logic and the LED/LCD status stages. It replaces the inline long-press counter with a debounced, glitch-proof detector.
One instance is used per key (key_up, key_down, ball_release_button). All instances run in the 12 MHz domain.

Parameters:
CLK_HZ, 12000000, input clock frequency in Hz.
DEBOUNCE_MS, 20, time a level must stay stable to be accepted; DEB_CYC = CLK_HZ/1000*DEBOUNCE_MS.
LONG_PRESS_MS, 3000, hold time for a long press; LONG_CYC = CLK_HZ/1000*LONG_PRESS_MS.
ACTIVE_LOW, 1, 1 means key_in = 0 is pressed; 0 means key_in = 1 is pressed.
REPEAT_MS, 200, auto-repeat period; REP_CYC = CLK_HZ/1000*REPEAT_MS (used only with the optional feature).

Ports:
clk  input  1  system clock (12 MHz).
rst  input  1  asynchronous, active-high reset.
key_in  input  1  raw asynchronous key pin.
key_level  output  1  debounced pressed level (1 = pressed).
press_pulse  output  1  one-cycle pulse when a press is accepted.
release_pulse  output  1  one-cycle pulse when a release is accepted.
short_press  output  1  one-cycle pulse on release if the hold was shorter than LONG_CYC.
long_press  output  1  one-cycle pulse when the hold reaches LONG_CYC.
repeat_pulse  output  1  auto-repeat pulse; tied 0 when the optional feature is off.
hold_active  output  1  1 while in LONG_HELD or in DEB_RELEASE entered from LONG_HELD.

Behaviour:
- Reset and synchroniser
  - Single clock. Reset is asynchronous and active-high.
  - On reset: all outputs 0, FSM = IDLE, counters 0.
  - Synchroniser flops reset to the released level, so reset never produces a pulse.
  - key_in passes through a 2-flop synchroniser, then is normalised by ACTIVE_LOW to kp (1 = pressed).
- FSM states: IDLE, DEB_PRESS, PRESSED, LONG_HELD, DEB_RELEASE.
- IDLE
  - kp = 1 → DEB_PRESS, deb_cnt = 1.
- DEB_PRESS
  - kp = 0 → IDLE, deb_cnt = 0, no output.
  - kp = 1 and deb_cnt == DEB_CYC-1 → PRESSED: press_pulse = 1 for one cycle, key_level = 1, hold_cnt = 0.
  - Otherwise deb_cnt increments.
- PRESSED
  - hold_cnt increments each cycle.
  - hold_cnt == LONG_CYC-1 → LONG_HELD: long_press = 1 for one cycle, long_done = 1.
  - kp = 0 → DEB_RELEASE, deb_cnt = 1; hold_cnt freezes.
- LONG_HELD
  - hold_cnt is no longer used.
  - kp = 0 → DEB_RELEASE, deb_cnt = 1.
- DEB_RELEASE
  - kp = 1 → return to PRESSED or LONG_HELD according to long_done; hold_cnt resumes from its frozen value; no pulses.
  - kp = 0 and deb_cnt == DEB_CYC-1 → IDLE: release_pulse = 1, key_level = 0, short_press = !long_done, long_done cleared.
- Timing and widths
  - Latency: with kp stable from the first synchronised cycle, press_pulse rises exactly DEB_CYC+2 clocks after the key_in edge. The same applies to release_pulse.
  - Counter widths are $clog2 of the largest cycle constant plus 1.
  - Counters never wrap; they are compared with ==, and the state change stops them.
  - All pulse outputs are registered and high for exactly one cycle.
  - short_press and long_press are never both asserted for the same hold.
- Reset mid-operation (any state) returns to IDLE immediately with no pulse. The next accepted press requires the full debounce time.

Optional Feature:
KEY_AUTO_REPEAT_EN
- Defined:
  - In LONG_HELD, rep_cnt counts; repeat_pulse is 1 for one cycle every REP_CYC clocks.
  - The first repeat pulse occurs REP_CYC clocks after long_press.
  - rep_cnt clears on leaving LONG_HELD. It freezes during DEB_RELEASE and resumes if the bounce returns to LONG_HELD.
- Not defined: no rep_cnt logic is synthesised; repeat_pulse = 0 constantly.

Decomposition:
- Package ballplayer_key_pkg holds:
  - the state encoding (localparams, 3 bits: IDLE = 0, DEB_PRESS = 1, PRESSED = 2, LONG_HELD = 3, DEB_RELEASE = 4);
  - the ms-to-cycles constant function.
- Sub-module key_sync2: 2-flop synchroniser with a parameterised reset value; asynchronous, active-high rst.
- The FSM and counters stay in key_press_detector.

Test Plan:
All scenarios use CLK_HZ = 1000, DEBOUNCE_MS = 5, LONG_PRESS_MS = 50, REPEAT_MS = 10, ACTIVE_LOW = 1, so DEB_CYC = 5, LONG_CYC = 50, REP_CYC = 10.
1. Clean press: key_in 1→0 held 20 cycles, then released → press_pulse at cycle 7, key_level = 1; release_pulse and short_press together 7 cycles after release; long_press never asserted.
2. Bounce: key_in low 3 cycles, high 2, low 3, then high → no pulse of any kind; key_level stays 0.
3. Long hold: key_in low 80 cycles → press_pulse at 7, long_press at 57, hold_active = 1 from 57; on release: release_pulse = 1, short_press = 0.
4. Release bounce during hold: a 2-cycle high glitch at cycle 30 of the hold → no release_pulse; long_press still fires, 2 cycles later than without the glitch (hold_cnt frozen).
5. Reset mid-hold: rst asserted for 1 cycle at cycle 40 of a press → all outputs 0 at once; no long_press; a new press needs the full 7-cycle latency.
6. With KEY_AUTO_REPEAT_EN defined: 100-cycle hold → repeat_pulse at cycles 67, 77, 87, 97; without the macro → repeat_pulse = 0 throughout.

Source files
------------

// File: rtl/ballplayer_key_pkg.sv
// ============================================================================
// Module      : ballplayer_key_pkg
// Description : Shared FSM state encoding and ms-to-cycles helper for the
//               key press detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ballplayer_key_pkg;

  localparam logic [2:0] c_ST_IDLE        = 3'd0;
  localparam logic [2:0] c_ST_DEB_PRESS   = 3'd1;
  localparam logic [2:0] c_ST_PRESSED     = 3'd2;
  localparam logic [2:0] c_ST_LONG_HELD   = 3'd3;
  localparam logic [2:0] c_ST_DEB_RELEASE = 3'd4;

  // Divide first so 12 MHz * several seconds stays inside 32 bits.
  function automatic int unsigned ms_to_cyc(input int unsigned clk_hz,
                                             input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_sync2.sv
// ============================================================================
// Module      : key_sync2
// Description : Two-flop synchroniser with a parameterised reset value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_q    <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_q    <= r_meta;
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/key_press_detector.sv
// ============================================================================
// Module      : key_press_detector
// Description : Debounced push-button conditioner producing press, release,
//               short-press, long-press (and optional auto-repeat) pulses.
//               Optional feature macro: KEY_AUTO_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_press_detector
  import ballplayer_key_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 12000000,
  parameter int unsigned DEBOUNCE_MS   = 20,
  parameter int unsigned LONG_PRESS_MS = 3000,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned REPEAT_MS     = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic hold_active
);

  localparam int unsigned c_DEB_CYC  = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned c_LONG_CYC = ms_to_cyc(CLK_HZ, LONG_PRESS_MS);
  localparam int unsigned c_REP_CYC  = ms_to_cyc(CLK_HZ, REPEAT_MS);
  localparam int unsigned c_MAX_DL   = (c_DEB_CYC > c_LONG_CYC) ? c_DEB_CYC : c_LONG_CYC;
  localparam int unsigned c_MAX_CYC  = (c_MAX_DL > c_REP_CYC) ? c_MAX_DL : c_REP_CYC;
  localparam int          c_CNT_W    = $clog2(c_MAX_CYC) + 1;

  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_DEB_LAST  = c_CNT_W'(c_DEB_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_LONG_LAST = c_CNT_W'(c_LONG_CYC - 1);

  logic w_key_sync;
  logic w_kp;

  logic [2:0]         r_state,    w_state_nxt;
  logic [c_CNT_W-1:0] r_deb_cnt,  w_deb_cnt_nxt;
  logic [c_CNT_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic               r_long_done, w_long_done_nxt;
  logic               r_key_level, w_key_level_nxt;
  logic               r_press,     w_press_nxt;
  logic               r_release,   w_release_nxt;
  logic               r_short,     w_short_nxt;
  logic               r_long,      w_long_nxt;
  logic               r_hold_act,  w_hold_act_nxt;

  // Reset value is the released pin level so reset can never fake a press.
  key_sync2 #(
    .RESET_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_in),
    .q   (w_key_sync)
  );

  assign w_kp = w_key_sync ^ ACTIVE_LOW;

  always_comb begin
    w_state_nxt     = r_state;
    w_deb_cnt_nxt   = r_deb_cnt;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_long_done_nxt = r_long_done;
    w_key_level_nxt = r_key_level;
    w_press_nxt     = 1'b0;
    w_release_nxt   = 1'b0;
    w_short_nxt     = 1'b0;
    w_long_nxt      = 1'b0;

    case (r_state)
      c_ST_IDLE: begin
        w_deb_cnt_nxt = '0;
        if (w_kp) begin
          w_state_nxt   = c_ST_DEB_PRESS;
          w_deb_cnt_nxt = c_CNT_ONE;
        end
      end

      c_ST_DEB_PRESS: begin
        if (!w_kp) begin
          w_state_nxt   = c_ST_IDLE;
          w_deb_cnt_nxt = '0;
        end else if (r_deb_cnt == c_DEB_LAST) begin
          w_state_nxt     = c_ST_PRESSED;
          w_deb_cnt_nxt   = '0;
          w_hold_cnt_nxt  = '0;
          w_press_nxt     = 1'b1;
          w_key_level_nxt = 1'b1;
        end else begin
          w_deb_cnt_nxt = r_deb_cnt + c_CNT_ONE;
        end
      end

      // The hold counter still advances on the cycle the release is first
      // seen, so a bounce costs exactly its duration in DEB_RELEASE.
      c_ST_PRESSED: begin
        if (r_hold_cnt == c_LONG_LAST) begin
          w_state_nxt     = c_ST_LONG_HELD;
          w_long_nxt      = 1'b1;
          w_long_done_nxt = 1'b1;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + c_CNT_ONE;
          if (!w_kp) begin
            w_state_nxt   = c_ST_DEB_RELEASE;
            w_deb_cnt_nxt = c_CNT_ONE;
          end
        end
      end

      c_ST_LONG_HELD: begin
        if (!w_kp) begin
          w_state_nxt   = c_ST_DEB_RELEASE;
          w_deb_cnt_nxt = c_CNT_ONE;
        end
      end

      c_ST_DEB_RELEASE: begin
        if (w_kp) begin
          w_state_nxt   = r_long_done ? c_ST_LONG_HELD : c_ST_PRESSED;
          w_deb_cnt_nxt = '0;
        end else if (r_deb_cnt == c_DEB_LAST) begin
          w_state_nxt     = c_ST_IDLE;
          w_deb_cnt_nxt   = '0;
          w_hold_cnt_nxt  = '0;
          w_release_nxt   = 1'b1;
          w_key_level_nxt = 1'b0;
          w_short_nxt     = !r_long_done;
          w_long_done_nxt = 1'b0;
        end else begin
          w_deb_cnt_nxt = r_deb_cnt + c_CNT_ONE;
        end
      end

      default: begin
        w_state_nxt     = c_ST_IDLE;
        w_deb_cnt_nxt   = '0;
        w_hold_cnt_nxt  = '0;
        w_long_done_nxt = 1'b0;
        w_key_level_nxt = 1'b0;
      end
    endcase

    // long_done is only set in LONG_HELD, so outside IDLE it marks that phase.
    w_hold_act_nxt = w_long_done_nxt && (w_state_nxt != c_ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_ST_IDLE;
      r_deb_cnt   <= '0;
      r_hold_cnt  <= '0;
      r_long_done <= 1'b0;
      r_key_level <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_short     <= 1'b0;
      r_long      <= 1'b0;
      r_hold_act  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_deb_cnt   <= w_deb_cnt_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_long_done <= w_long_done_nxt;
      r_key_level <= w_key_level_nxt;
      r_press     <= w_press_nxt;
      r_release   <= w_release_nxt;
      r_short     <= w_short_nxt;
      r_long      <= w_long_nxt;
      r_hold_act  <= w_hold_act_nxt;
    end
  end

  assign key_level     = r_key_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign short_press   = r_short;
  assign long_press    = r_long;
  assign hold_active   = r_hold_act;

`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [c_CNT_W-1:0] c_REP_LAST = c_CNT_W'(c_REP_CYC - 1);

  logic [c_CNT_W-1:0] r_rep_cnt, w_rep_cnt_nxt;
  logic               r_repeat,  w_repeat_nxt;

  // Counts only in LONG_HELD, freezes through release bounces, clears in IDLE.
  always_comb begin
    w_rep_cnt_nxt = r_rep_cnt;
    w_repeat_nxt  = 1'b0;
    if (w_state_nxt == c_ST_IDLE) begin
      w_rep_cnt_nxt = '0;
    end else if (r_state == c_ST_LONG_HELD) begin
      if (r_rep_cnt == c_REP_LAST) begin
        w_repeat_nxt  = 1'b1;
        w_rep_cnt_nxt = '0;
      end else begin
        w_rep_cnt_nxt = r_rep_cnt + c_CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rep_cnt <= '0;
      r_repeat  <= 1'b0;
    end else begin
      r_rep_cnt <= w_rep_cnt_nxt;
      r_repeat  <= w_repeat_nxt;
    end
  end

  assign repeat_pulse = r_repeat;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_key_press_detector.sv
// ============================================================================
// Module      : tb_key_press_detector
// Description : Directed self-checking bench for key_press_detector using
//               DEB_CYC = 5, LONG_CYC = 50, REP_CYC = 10.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_press_detector;

`ifdef KEY_AUTO_REPEAT_EN
  localparam bit c_REP_ON = 1'b1;
`else
  localparam bit c_REP_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  logic key_in;
  logic key_level;
  logic press_pulse;
  logic release_pulse;
  logic short_press;
  logic long_press;
  logic repeat_pulse;
  logic hold_active;

  logic [6:0] obs;
  int n_assert;
  int n_fail;

  key_press_detector #(
    .CLK_HZ        (1000),
    .DEBOUNCE_MS   (5),
    .LONG_PRESS_MS (50),
    .ACTIVE_LOW    (1'b1),
    .REPEAT_MS     (10)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key_in        (key_in),
    .key_level     (key_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .short_press   (short_press),
    .long_press    (long_press),
    .repeat_pulse  (repeat_pulse),
    .hold_active   (hold_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {key_level, press, release, short, long, hold_active, repeat}
  assign obs = {key_level, press_pulse, release_pulse, short_press,
                long_press, hold_active, repeat_pulse};

  task automatic idle_cycles(input int n);
    key_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    key_in = 1'b1;
    #1 rst = 1'b1;
    #1;
    n_assert++;
    if (obs !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_async: got %b expected %b", obs, 7'b0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk);
      #1;
      n_assert++;
      if (obs !== 7'b0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: got %b expected %b", n, obs, 7'b0);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [6:0] exp;
    for (int n = 1; n <= 35; n++) begin
      key_in = (n <= 20) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      exp    = '0;
      exp[6] = (n >= 7) && (n <= 26);
      exp[5] = (n == 7);
      exp[4] = (n == 27);
      exp[3] = (n == 27);
      n_assert++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL clean_press cycle %0d: got %b expected %b", n, obs, exp);
      end
    end
    idle_cycles(5);
  endtask

  task automatic test_bounce();
    for (int n = 1; n <= 20; n++) begin
      key_in = ((n >= 1 && n <= 3) || (n >= 6 && n <= 8)) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      n_assert++;
      if (obs !== 7'b0) begin
        n_fail++;
        $display("FAIL bounce cycle %0d: got %b expected %b", n, obs, 7'b0);
      end
    end
    idle_cycles(5);
  endtask

  task automatic test_long_hold();
    logic [6:0] exp;
    for (int n = 1; n <= 95; n++) begin
      key_in = (n <= 80) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      exp    = '0;
      exp[6] = (n >= 7) && (n <= 86);
      exp[5] = (n == 7);
      exp[4] = (n == 87);
      exp[2] = (n == 57);
      exp[1] = (n >= 57) && (n <= 86);
      exp[0] = c_REP_ON && ((n == 67) || (n == 77));
      n_assert++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL long_hold cycle %0d: got %b expected %b", n, obs, exp);
      end
    end
    idle_cycles(5);
  endtask

  // Two-cycle high glitch mid-hold: hold counter freezes, long press slips by 2.
  task automatic test_release_bounce();
    logic [6:0] exp;
    for (int n = 1; n <= 95; n++) begin
      key_in = ((n <= 80) && (n != 30) && (n != 31)) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      exp    = '0;
      exp[6] = (n >= 7) && (n <= 86);
      exp[5] = (n == 7);
      exp[4] = (n == 87);
      exp[2] = (n == 59);
      exp[1] = (n >= 59) && (n <= 86);
      exp[0] = c_REP_ON && ((n == 69) || (n == 79));
      n_assert++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL release_bounce cycle %0d: got %b expected %b", n, obs, exp);
      end
    end
    idle_cycles(5);
  endtask

  task automatic test_reset_mid_hold();
    logic [6:0] exp;
    for (int n = 1; n <= 40; n++) begin
      key_in = 1'b0;
      @(posedge clk);
      #1;
      exp    = '0;
      exp[6] = (n >= 7);
      exp[5] = (n == 7);
      n_assert++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL pre_reset cycle %0d: got %b expected %b", n, obs, exp);
      end
    end
    rst = 1'b1;
    #1;
    n_assert++;
    if (obs !== 7'b0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got %b expected %b", obs, 7'b0);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    // Key still held: a fresh press must take the full debounce latency.
    for (int m = 1; m <= 60; m++) begin
      @(posedge clk);
      #1;
      exp    = '0;
      exp[6] = (m >= 7);
      exp[5] = (m == 7);
      exp[2] = (m == 57);
      exp[1] = (m >= 57);
      n_assert++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL post_reset cycle %0d: got %b expected %b", m, obs, exp);
      end
    end
    idle_cycles(12);
  endtask

  task automatic test_auto_repeat();
    logic [6:0] exp;
    for (int n = 1; n <= 115; n++) begin
      key_in = (n <= 100) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      exp    = '0;
      exp[6] = (n >= 7) && (n <= 106);
      exp[5] = (n == 7);
      exp[4] = (n == 107);
      exp[2] = (n == 57);
      exp[1] = (n >= 57) && (n <= 106);
      exp[0] = c_REP_ON && ((n == 67) || (n == 77) || (n == 87) || (n == 97));
      n_assert++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL auto_repeat cycle %0d: got %b expected %b", n, obs, exp);
      end
    end
    idle_cycles(5);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b0;
    key_in   = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_hold();
    test_release_bounce();
    test_reset_mid_hold();
    test_auto_repeat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
